// File: rtl/arb_pkg.sv
// Shared definitions for the two-requester bus arbiter: FSM state encoding,
// the default burst limit and a small grant-decode helper.
package arb_pkg;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] GRANT0 = 2'b01;
  localparam logic [1:0] GRANT1 = 2'b10;

  localparam int MAX_BURST_DEFAULT = 4;

  // One-hot grant vector for a given state; anything not a grant state is 2'b00
  function automatic logic [1:0] grantOf(input logic [1:0] state);
    logic [1:0] g;
    g = 2'b00;
    if (state == GRANT0) g = 2'b01;
    if (state == GRANT1) g = 2'b10;
    return g;
  endfunction

endpackage

// File: rtl/mux8_bus_arbiter_mux.sv
// Existing 8-bit 2:1 data selector used to steer a requester's payload onto
// the shared bus. Select high picks input 1.
module Mux8Bit_2To1 (
  input  logic       i_sel,
  input  logic [7:0] i_data0,
  input  logic [7:0] i_data1,
  output logic [7:0] o_data
);

  // Pure combinational steering, no state
  assign o_data = i_sel ? i_data1 : i_data0;

endmodule

// File: rtl/mux8_bus_arbiter.sv
// Two-requester bus arbiter with bounded bursts. A registered three-state FSM
// owns the bus; the granted requester's payload is steered through an 8-bit
// 2:1 mux. Ties are broken against whoever was served last, and a requester
// may hold the bus for at most MAX_BURST transfers while the other waits.
module mux8_bus_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic       out_ready,
  output logic [1:0] grant,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] out_data,
  output logic       out_valid
);

  localparam logic [3:0] LP_MAX_BURST = 4'(MAX_BURST);

  logic [1:0] r_state;
  logic [3:0] r_burstCnt;
  logic       r_lastServed;

  logic [1:0] w_nextState;
  logic [3:0] w_nextBurstCnt;
  logic       w_nextLastServed;

  logic       w_sel;
  logic [7:0] w_muxData;
  logic       w_transfer;
  logic       w_burstDone;

  // Payload steering: requester 1 is selected only while it holds the grant
  assign w_sel = (r_state == GRANT1);

  Mux8Bit_2To1 u_dataMux (
    .i_sel   (w_sel),
    .i_data0 (data0),
    .i_data1 (data1),
    .o_data  (w_muxData)
  );

  assign grant       = grantOf(r_state);
  assign out_valid   = ((r_state == GRANT0) && req0) || ((r_state == GRANT1) && req1);
  assign out_data    = out_valid ? w_muxData : 8'h00;
  assign w_transfer  = out_valid && out_ready;
  assign ack0        = w_transfer && (r_state == GRANT0);
  assign ack1        = w_transfer && (r_state == GRANT1);
  assign w_burstDone = ((r_burstCnt + 4'd1) == LP_MAX_BURST);

  // Next-state, burst count and tie-break history; stalls leave everything as is
  always_comb begin
    w_nextState      = r_state;
    w_nextBurstCnt   = r_burstCnt;
    w_nextLastServed = r_lastServed;
    case (r_state)
      IDLE: begin
        if (req0 && req1) begin
          w_nextState = r_lastServed ? GRANT0 : GRANT1;
        end else if (req0) begin
          w_nextState = GRANT0;
        end else if (req1) begin
          w_nextState = GRANT1;
        end
      end
      GRANT0: begin
        if (!req0) begin
          w_nextState = req1 ? GRANT1 : IDLE;
        end else if (w_transfer) begin
          w_nextLastServed = 1'b0;
          if (w_burstDone) begin
            w_nextBurstCnt = 4'd0;
            if (req1) w_nextState = GRANT1;
          end else begin
            w_nextBurstCnt = r_burstCnt + 4'd1;
          end
        end
      end
      GRANT1: begin
        if (!req1) begin
          w_nextState = req0 ? GRANT0 : IDLE;
        end else if (w_transfer) begin
          w_nextLastServed = 1'b1;
          if (w_burstDone) begin
            w_nextBurstCnt = 4'd0;
            if (req0) w_nextState = GRANT0;
          end else begin
            w_nextBurstCnt = r_burstCnt + 4'd1;
          end
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
    if (w_nextState != r_state) begin
      w_nextBurstCnt = 4'd0;
    end
  end

  // State registers; reset parks in IDLE with requester 0 favoured on the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_burstCnt   <= 4'd0;
      r_lastServed <= 1'b1;
    end else begin
      r_state      <= w_nextState;
      r_burstCnt   <= w_nextBurstCnt;
      r_lastServed <= w_nextLastServed;
    end
  end

endmodule

// File: tb/tb_mux8_bus_arbiter.sv
// Directed bench for mux8_bus_arbiter. Inputs change 1 time unit after a rising
// edge; outputs are sampled on the following falling edge.
module tb_mux8_bus_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0;
  logic       req1;
  logic [7:0] data0;
  logic [7:0] data1;
  logic       out_ready;

  logic [1:0] grant;
  logic       ack0;
  logic       ack1;
  logic [7:0] out_data;
  logic       out_valid;

  logic [1:0] grant2;
  logic       ack0b;
  logic       ack1b;
  logic [7:0] outData2;
  logic       outValid2;

  int compareCount;
  int mismatchCount;
  int ackTally;

  mux8_bus_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .data0     (data0),
    .data1     (data1),
    .out_ready (out_ready),
    .grant     (grant),
    .ack0      (ack0),
    .ack1      (ack1),
    .out_data  (out_data),
    .out_valid (out_valid)
  );

  mux8_bus_arbiter #(.MAX_BURST(2)) dutBurst2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .data0     (data0),
    .data1     (data1),
    .out_ready (out_ready),
    .grant     (grant2),
    .ack0      (ack0b),
    .ack1      (ack1b),
    .out_data  (outData2),
    .out_valid (outValid2)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, wanted %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic r1, input logic [7:0] d0,
                               input logic [7:0] d1, input logic rdy);
    req0      = r0;
    req1      = r1;
    data0     = d0;
    data1     = d1;
    out_ready = rdy;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    rst_n         = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Reset state
    doReset();
    @(negedge clk);
    checkOutput("rst_grant", 16'(grant), 16'h0);
    checkOutput("rst_valid", 16'(out_valid), 16'h0);
    checkOutput("rst_acks", 16'({ack1, ack0}), 16'h0);
    checkOutput("rst_data", 16'(out_data), 16'h00);

    // Single request: grant next cycle, ack in that grant cycle
    nextCycle();
    applyStimulus(1'b1, 1'b0, 8'hA5, 8'h00, 1'b1);
    @(negedge clk);
    checkOutput("single_idle_grant", 16'(grant), 16'h0);
    checkOutput("single_idle_ack0", 16'(ack0), 16'h0);
    nextCycle();
    @(negedge clk);
    checkOutput("single_grant", 16'(grant), 16'h1);
    checkOutput("single_data", 16'(out_data), 16'hA5);
    checkOutput("single_valid", 16'(out_valid), 16'h1);
    checkOutput("single_ack0", 16'(ack0), 16'h1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 8'hA5, 8'h00, 1'b1);
    @(negedge clk);
    checkOutput("drop_valid", 16'(out_valid), 16'h0);
    checkOutput("drop_data_zero", 16'(out_data), 16'h00);
    checkOutput("drop_ack0", 16'(ack0), 16'h0);
    nextCycle();
    @(negedge clk);
    checkOutput("drop_idle", 16'(grant), 16'h0);

    // Tie after reset: requester 0 first, 4-transfer burst, then requester 1
    doReset();
    applyStimulus(1'b1, 1'b1, 8'h11, 8'h22, 1'b1);
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      @(negedge clk);
      checkOutput($sformatf("tie_g0_grant%0d", i), 16'(grant), 16'h1);
      checkOutput($sformatf("tie_g0_data%0d", i), 16'(out_data), 16'h11);
      checkOutput($sformatf("tie_g0_ack%0d", i), 16'({ack1, ack0}), 16'h1);
    end
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      @(negedge clk);
      checkOutput($sformatf("tie_g1_grant%0d", i), 16'(grant), 16'h2);
      checkOutput($sformatf("tie_g1_data%0d", i), 16'(out_data), 16'h22);
      checkOutput($sformatf("tie_g1_ack%0d", i), 16'({ack1, ack0}), 16'h2);
    end
    nextCycle();
    @(negedge clk);
    checkOutput("tie_back_g0", 16'(grant), 16'h1);

    // Stall: req1 with out_ready low for 5 cycles, then one ack on ready
    doReset();
    applyStimulus(1'b0, 1'b1, 8'h00, 8'h3C, 1'b0);
    ackTally = 0;
    nextCycle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("stall_grant%0d", i), 16'(grant), 16'h2);
      checkOutput($sformatf("stall_valid%0d", i), 16'(out_valid), 16'h1);
      checkOutput($sformatf("stall_data%0d", i), 16'(out_data), 16'h3C);
      if (ack1) ackTally++;
      nextCycle();
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("stall_ready_ack1", 16'(ack1), 16'h1);
    checkOutput("stall_ready_grant", 16'(grant), 16'h2);
    if (ack1) ackTally++;
    nextCycle();
    req1 = 1'b0;
    @(negedge clk);
    if (ack1) ackTally++;
    checkOutput("stall_ack1_count", 16'(ackTally), 16'h1);

    // MAX_BURST=2 with no competitor: continuous acks, grant stays on requester 0
    doReset();
    applyStimulus(1'b1, 1'b0, 8'h5A, 8'h00, 1'b1);
    for (int i = 0; i < 6; i++) begin
      nextCycle();
      @(negedge clk);
      checkOutput($sformatf("burst2_grant%0d", i), 16'(grant2), 16'h1);
      checkOutput($sformatf("burst2_ack0_%0d", i), 16'(ack0b), 16'h1);
      checkOutput($sformatf("burst2_data%0d", i), 16'(outData2), 16'h5A);
    end

    // Reset asserted during the second transfer of a GRANT1 burst
    doReset();
    applyStimulus(1'b1, 1'b1, 8'h11, 8'h22, 1'b1);
    repeat (6) nextCycle();
    @(negedge clk);
    checkOutput("midrst_pre_grant", 16'(grant), 16'h2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_grant", 16'(grant), 16'h0);
    checkOutput("midrst_valid", 16'(out_valid), 16'h0);
    checkOutput("midrst_acks", 16'({ack1, ack0}), 16'h0);
    nextCycle();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_idle", 16'(grant), 16'h0);
    nextCycle();
    @(negedge clk);
    checkOutput("midrst_tie_g0", 16'(grant), 16'h1);

    // Withdrawal: req0 drops in GRANT0 without an ack, bus passes to requester 1
    doReset();
    applyStimulus(1'b1, 1'b1, 8'h77, 8'h88, 1'b0);
    nextCycle();
    @(negedge clk);
    checkOutput("wd_grant0", 16'(grant), 16'h1);
    checkOutput("wd_ack0_stall", 16'(ack0), 16'h0);
    nextCycle();
    req0 = 1'b0;
    @(negedge clk);
    checkOutput("wd_ack0_drop", 16'(ack0), 16'h0);
    checkOutput("wd_valid_drop", 16'(out_valid), 16'h0);
    nextCycle();
    @(negedge clk);
    checkOutput("wd_grant1", 16'(grant), 16'h2);
    checkOutput("wd_data1", 16'(out_data), 16'h88);
    checkOutput("wd_no_ack0", 16'(ack0), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

  // Safety net so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, wanted completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
